// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default sizes,
// the address-width helper, the hard-wired zero register index and the
// packed read-address vector type for the default configuration.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;
  localparam int ZERO_REG  = 0;

  // Ceiling log2, used to size register addresses from the register count.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  typedef logic [NRD_DEF*clog2(NREGS_DEF)-1:0] addr_vec_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-destination scoreboard for regfile_mp.
// Issue sets a register's pending bit, a write clears it, and an issue that
// collides with a write to the same register leaves it set (newer producer).
// Optional macro REGFILE_BYPASS_EN: a same-cycle write to the addressed
// register hides its pending bit unless that register is also being issued.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = clog2(NREGS),
  parameter int NRD   = 2,
  parameter int NWR   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_rd,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy
);

  logic [NREGS-1:0] pending_reg;

  // Pending vector: clear on write, then set on issue so issue wins a collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_reg <= '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] != AW'(ZERO_REG))) begin
          pending_reg[wr_addr[w*AW +: AW]] <= 1'b0;
        end
      end
      if (iss_en && (iss_rd != AW'(ZERO_REG))) begin
        pending_reg[iss_rd] <= 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_busy
      logic [AW-1:0] addr;
      assign addr = rd_addr[gi*AW +: AW];

`ifdef REGFILE_BYPASS_EN
      // Busy lookup with write forwarding; a same-cycle issue keeps the stored bit.
      always_comb begin
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < NWR; w++) begin
          if (wr_en[w] && (wr_addr[w*AW +: AW] == addr)) begin
            hit = 1'b1;
          end
        end
        rd_busy[gi] = pending_reg[addr];
        if (addr == AW'(ZERO_REG)) begin
          rd_busy[gi] = 1'b0;
        end else if (hit && !(iss_en && (iss_rd == addr))) begin
          rd_busy[gi] = 1'b0;
        end
      end
`else
      // Busy lookup from registered state only; register 0 is never pending.
      always_comb begin
        rd_busy[gi] = 1'b0;
        if (addr != AW'(ZERO_REG)) begin
          rd_busy[gi] = pending_reg[addr];
        end
      end
`endif
    end
  endgenerate

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with pending scoreboard.
// NRD combinational read ports, NWR write ports (higher index wins on an
// address conflict), register 0 hard-wired to zero.
// Optional macro REGFILE_BYPASS_EN: forwards same-cycle write data to reads.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  parameter int AW    = clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_rd
);

  logic [XLEN-1:0] regs_reg [NREGS];

  // Storage update: ports applied in ascending order so the highest index wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_reg[r] <= '0;
      end
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] != AW'(ZERO_REG))) begin
          regs_reg[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
        end
      end
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW),
    .NRD   (NRD),
    .NWR   (NWR)
  ) u_scoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .iss_en  (iss_en),
    .iss_rd  (iss_rd),
    .rd_addr (rd_addr),
    .rd_busy (rd_busy)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_read
      logic [AW-1:0] addr;
      assign addr = rd_addr[gi*AW +: AW];

      // Read mux; register 0 always returns zero regardless of storage.
      always_comb begin
        rd_data[gi*XLEN +: XLEN] = '0;
        if (addr != AW'(ZERO_REG)) begin
          rd_data[gi*XLEN +: XLEN] = regs_reg[addr];
`ifdef REGFILE_BYPASS_EN
          for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && (wr_addr[w*AW +: AW] == addr)) begin
              rd_data[gi*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
            end
          end
`endif
        end
      end
    end
  endgenerate

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the next-generation RISC-V core. It replaces the fixed 2-read/1-write register file used in the single-cycle datapath. It adds configurable read and write port counts, a synchronous active-low clear, deterministic write-conflict resolution, and a per-register pending scoreboard so a pipelined or multi-issue core can stall on unresolved destinations. An optional write-to-read bypass is also provided. It sits between decode (read/issue) and writeback (write/clear).

## Interface
- XLEN, 32: data width in bits.
- NREGS, 32: register count; power of two, ≥2; AW = log2(NREGS).
- NRD, 2: read ports.
- NWR, 2: write ports; a higher index has higher priority.
- clk  in  1  rising-edge clock (single clock domain).
- rst_n  in  1  reset; synchronous, active-low.
- rd_addr  in  NRD*AW  read addresses, port p at bits [p*AW +: AW].
- rd_data  out  NRD*XLEN  read data, port p at [p*XLEN +: XLEN].
- rd_busy  out  NRD  register addressed by port p is pending.
- wr_en  in  NWR  write strobes.
- wr_addr  in  NWR*AW  write addresses.
- wr_data  in  NWR*XLEN  write data.
- iss_en  in  1  mark a destination pending.
- iss_rd  in  AW  destination register to mark.

## Operation
- **Storage:** NREGS×XLEN storage plus an NREGS-bit pending vector.
- **Register 0:** reads 0 and is never busy; writes and issues to register 0 are ignored.
- **Reads:** combinational. rd_data[p] = regs[rd_addr[p]] and rd_busy[p] = pending[rd_addr[p]], with the bypass rules in Configuration applied.
- **Writes:**
  - On a rising edge with rst_n=1, every port with wr_en[w]=1 and wr_addr[w]≠0 writes wr_data[w].
  - If several ports target the same address, the highest w wins.
  - Each write also clears pending[wr_addr[w]].
- **Issue:** with iss_en=1 and iss_rd≠0, pending[iss_rd] is set on the edge.
- **Issue/write collision:** if an issue and a write target the same register in one cycle, pending ends at 1 and the data is still written. Issue wins because it is a newer producer.
- **Reset:** rst_n=0 sampled at an edge clears all registers and all pending bits. Any writes or issues presented in that cycle are discarded.
- **Outputs during reset:** reads stay combinational; after the reset edge they return 0 and not-busy.
- **Address range:** out-of-range addresses cannot occur, because NREGS is a power of two.

## Timing
- Read latency is 0 cycles (combinational from rd_addr).
- A write in cycle N is visible on rd_data from cycle N+1 without bypass, or in cycle N with bypass.
- pending set by an issue in cycle N: rd_busy is asserted from N+1.
- pending cleared by a write in cycle N: rd_busy is deasserted from N+1 without bypass, or in N with bypass.
- Reset is applied at the edge where rst_n=0. The first usable cycle is the one after rst_n returns to 1.
- There is no handshake. All strobes are single-cycle qualifiers.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- **Defined:**
  - If any wr_en[w] is active with wr_addr[w]=rd_addr[p]≠0, rd_data[p] returns the highest-priority matching wr_data in the same cycle.
  - rd_busy[p] is then 0, unless iss_en targets that register in the same cycle, in which case it follows the registered pending bit.
  - Issue never forwards.
- **Undefined:** reads always return registered state, and the write-before-read hazard must be handled outside the block.

## Structure
- **Shared package:** regfile_pkg holds:
  - default XLEN/NREGS constants;
  - a clog2 function for AW;
  - the ZERO_REG = 0 constant;
  - a typedef for the packed address vector.
- **Sub-module:** regfile_scoreboard, which owns the pending vector, issue set, write clear and the collision rule. It exposes a busy output per read port.
- **Top level:** regfile_mp instantiates regfile_scoreboard and implements storage, write priority and bypass.
- **Debug:** no $display in synthesised RTL; debug prints belong in the bench.

## Test plan
- Reset, then read all registers → every rd_data=0 and rd_busy=0. Then write x5=0xDEADBEEF and assert rst_n=0 in the same cycle → x5 reads 0 afterwards.
- Write x0=0x1234 and issue x0 → rd_data for x0 reads 0 and rd_busy=0.
- Port0 writes x3=0xAAAA0000 and port1 writes x3=0x5555FFFF in the same cycle → x3 reads 0x5555FFFF next cycle.
- Issue x7 in cycle N → rd_busy=1 at N+1. Write x7=0x42 in cycle N+3 → busy=0 and data=0x42 at N+4 (at N+3 with REGFILE_BYPASS_EN).
- Issue x9 and write x9=0x99 in the same cycle → x9 reads 0x99 with rd_busy=1 the next cycle.
- With REGFILE_BYPASS_EN: write x10=0xCAFEBABE while reading x10 on both ports in the same cycle → both ports return 0xCAFEBABE that cycle. Without the macro, they return the old value.
